bitslam_bus_master: RTL and testbench

//  Arbitrates two write requesters (host shim, on-chip patch sequencer) onto the 6-bit shared

---
 rtl/bitslam_bus_master.sv | 144 ++++++++++++++
 tb/tb_bitslam_bus_master.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bitslam_bus_master.sv
// Round-robin write arbiter for the bitslam phase core's shared addr/data config bus.
// Each write is an ADDR cycle then a DATA cycle; the ADDR cycle is skipped when the core already holds the address.
module bitslam_bus_master #(
    parameter int unsigned  W          = 6,
    parameter logic [W-1:0] RESET_ADDR = 6'h3F
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_addr,
    input  logic [W-1:0] req0_data,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_addr,
    input  logic [W-1:0] req1_data,
    output logic         bus_sel,
    output logic [W-1:0] bus_val,
    output logic         busy,
    output logic         last_grant
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    state_e       state_r, state_nxt_s;
    logic [W-1:0] hold_addr_r, hold_data_r, shadow_addr_r, bus_val_r;
    logic         shadow_ok_r, last_grant_r, bus_sel_r, busy_r;
    logic         grant_s, grant_idx_s, hit_s;
    logic [W-1:0] pick_addr_s, pick_data_s;
    logic [W-1:0] hold_addr_nxt_s, hold_data_nxt_s, shadow_addr_nxt_s, bus_val_nxt_s;
    logic         bus_sel_nxt_s, busy_nxt_s, ready0_s, ready1_s;

    // Arbitration and address-hit detection; IDLE drives sel=0, so the core latch is valid this cycle
    always_comb begin
        grant_s     = 1'b0;
        grant_idx_s = 1'b0;
        if (state_r == ST_IDLE || state_r == ST_DATA) begin
            if (req0_valid && req1_valid) begin
                grant_s     = 1'b1;
                grant_idx_s = ~last_grant_r;
            end else if (req0_valid) begin
                grant_s     = 1'b1;
                grant_idx_s = 1'b0;
            end else if (req1_valid) begin
                grant_s     = 1'b1;
                grant_idx_s = 1'b1;
            end else begin
                grant_s     = 1'b0;
                grant_idx_s = 1'b0;
            end
        end else begin
            grant_s     = 1'b0;
            grant_idx_s = 1'b0;
        end
        pick_addr_s = grant_idx_s ? req1_addr : req0_addr;
        pick_data_s = grant_idx_s ? req1_data : req0_data;
        hit_s = (shadow_ok_r || (state_r == ST_IDLE)) && (pick_addr_s == shadow_addr_r);
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE, ST_DATA: begin
                if (grant_s) begin
                    state_nxt_s = hit_s ? ST_DATA : ST_ADDR;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADDR: state_nxt_s = ST_DATA;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output decode: readys plus next values of the registered bus outputs
    always_comb begin
        ready0_s          = grant_s & ~grant_idx_s;
        ready1_s          = grant_s & grant_idx_s;
        hold_addr_nxt_s   = grant_s ? pick_addr_s : hold_addr_r;
        hold_data_nxt_s   = grant_s ? pick_data_s : hold_data_r;
        shadow_addr_nxt_s = (state_r == ST_ADDR) ? hold_addr_r : shadow_addr_r;
        case (state_nxt_s)
            ST_ADDR: bus_val_nxt_s = hold_addr_nxt_s;
            ST_DATA: bus_val_nxt_s = hold_data_nxt_s;
            default: bus_val_nxt_s = shadow_addr_nxt_s;
        endcase
        bus_sel_nxt_s = (state_nxt_s == ST_DATA);
        busy_nxt_s    = (state_nxt_s != ST_IDLE);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Holding, shadow and grant-history registers; every sel=0 cycle validates the shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_addr_r   <= {W{1'b0}};
            hold_data_r   <= {W{1'b0}};
            shadow_addr_r <= RESET_ADDR;
            shadow_ok_r   <= 1'b0;
            last_grant_r  <= 1'b1;
        end else begin
            hold_addr_r   <= hold_addr_nxt_s;
            hold_data_r   <= hold_data_nxt_s;
            shadow_addr_r <= shadow_addr_nxt_s;
            shadow_ok_r   <= shadow_ok_r | (state_r != ST_DATA);
            if (grant_s) begin
                last_grant_r <= grant_idx_s;
            end
        end
    end

    // Registered bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_sel_r <= 1'b0;
            bus_val_r <= RESET_ADDR;
            busy_r    <= 1'b0;
        end else begin
            bus_sel_r <= bus_sel_nxt_s;
            bus_val_r <= bus_val_nxt_s;
            busy_r    <= busy_nxt_s;
        end
    end

    assign req0_ready = ready0_s;
    assign req1_ready = ready1_s;
    assign bus_sel    = bus_sel_r;
    assign bus_val    = bus_val_r;
    assign busy       = busy_r;
    assign last_grant = last_grant_r;

endmodule

// File: tb/tb_bitslam_bus_master.sv
// Bench for bitslam_bus_master: transaction-level bus model checked every cycle,
// a small phase-core register model, and directed scenarios with literal expectations.
module tb_bitslam_bus_master;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [5:0] req0_addr = 6'd0, req0_data = 6'd0, req1_addr = 6'd0, req1_data = 6'd0;
    logic       bus_sel, busy, last_grant;
    logic [5:0] bus_val;

    int n_checks = 0;
    int n_fail   = 0;

    bitslam_bus_master dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
        .bus_sel(bus_sel), .bus_val(bus_val), .busy(busy), .last_grant(last_grant)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Phase core model: latches address on sel=0, writes register on sel=1; not reset by the master
    logic [5:0] core_regs [0:63] = '{default: 6'd0};
    logic [5:0] core_addr = 6'd0;
    always @(posedge clk) begin
        if (!reset) begin
            if (bus_sel) core_regs[core_addr] <= bus_val;
            else         core_addr <= bus_val;
        end
    end

    // Model: queue of bus cycles still owed to accepted writes, plus what the core has latched
    typedef struct packed { logic sel; logic [5:0] val; } cyc_t;
    cyc_t       exp_q[$];
    logic [5:0] m_addr;
    logic       m_ok, m_lg;
    logic [8:0] trace[$];   // {ready0, ready1, sel, val} per out-of-reset cycle

    always @(negedge clk) begin
        cyc_t    e;
        logic    eb, g, gi;
        logic [5:0] a, d;
        if (reset) begin
            check("rst_sel", bus_sel, 1'b0);
            check("rst_val", bus_val, 6'h3F);
            check("rst_busy", busy, 1'b0);
            check("rst_ready", {req0_ready, req1_ready}, 2'b00);
            check("rst_last_grant", last_grant, 1'b1);
            exp_q.delete();
            m_addr = 6'h3F; m_ok = 1'b0; m_lg = 1'b1;
        end else begin
            if (exp_q.size() > 0) begin e = exp_q.pop_front(); eb = 1'b1; end
            else begin e = {1'b0, m_addr}; eb = 1'b0; end
            check("bus_sel", bus_sel, e.sel);
            check("bus_val", bus_val, e.val);
            check("busy", busy, eb);
            check("last_grant", last_grant, m_lg);
            if (!e.sel) begin m_addr = e.val; m_ok = 1'b1; end
            g = 1'b0; gi = 1'b0;
            if (exp_q.size() == 0) begin
                if (req0_valid && req1_valid) begin g = 1'b1; gi = ~m_lg; end
                else if (req0_valid) begin g = 1'b1; gi = 1'b0; end
                else if (req1_valid) begin g = 1'b1; gi = 1'b1; end
            end
            check("ready0", req0_ready, g & ~gi);
            check("ready1", req1_ready, g & gi);
            if (g) begin
                a = gi ? req1_addr : req0_addr;
                d = gi ? req1_data : req0_data;
                if (!(m_ok && a == m_addr)) exp_q.push_back({1'b0, a});
                exp_q.push_back({1'b1, d});
                m_lg = gi;
            end
            trace.push_back({req0_ready, req1_ready, bus_sel, bus_val});
        end
    end

    task automatic send(input int idx, input logic [5:0] a, input logic [5:0] d);
        logic done = 1'b0;
        if (idx == 0) begin req0_valid = 1'b1; req0_addr = a; req0_data = d; end
        else          begin req1_valid = 1'b1; req1_addr = a; req1_data = d; end
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if ((idx == 0) ? req0_ready : req1_ready) done = 1'b1;
        end
        check("send_accepted", done, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic release_req(input int idx);
        if (idx == 0) req0_valid = 1'b0;
        else          req1_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic tr_chk(input string name, input int i, input logic [8:0] exp);
        if (i < trace.size()) check(name, trace[i], exp);
        else check({name, "_missing"}, 32'(trace.size()), 32'(i + 1));
    endtask

    initial begin
        int       grants[$];
        logic [5:0] datas[$];
        // 1: idle after reset
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        trace.delete();
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) tr_chk("idle", i, {2'b00, 1'b0, 6'h3F});

        // 2: single write, miss after reset
        trace.delete();
        send(0, 6'd0, 6'd9);
        release_req(0);
        repeat (3) @(posedge clk);
        #1;
        tr_chk("w1_accept", 0, {2'b10, 1'b0, 6'h3F});
        tr_chk("w1_addr", 1, {2'b00, 1'b0, 6'd0});
        tr_chk("w1_data", 2, {2'b00, 1'b1, 6'd9});
        check("max_phase_9", core_regs[0], 6'd9);

        // 3: same-address burst
        do_reset();
        trace.delete();
        send(0, 6'd0, 6'd5);
        send(0, 6'd0, 6'd7);
        send(0, 6'd0, 6'd2);
        release_req(0);
        repeat (3) @(posedge clk);
        #1;
        tr_chk("burst_accept", 0, {2'b10, 1'b0, 6'h3F});
        tr_chk("burst_addr", 1, {2'b00, 1'b0, 6'd0});
        tr_chk("burst_d5", 2, {2'b10, 1'b1, 6'd5});
        tr_chk("burst_d7", 3, {2'b10, 1'b1, 6'd7});
        tr_chk("burst_d2", 4, {2'b00, 1'b1, 6'd2});
        tr_chk("burst_idle", 5, {2'b00, 1'b0, 6'd0});

        // 4: both requesters, different addresses
        do_reset();
        trace.delete();
        fork
            begin send(0, 6'd1, 6'd10); send(0, 6'd1, 6'd11); release_req(0); end
            begin send(1, 6'd2, 6'd20); send(1, 6'd2, 6'd21); release_req(1); end
        join
        repeat (4) @(posedge clk);
        #1;
        foreach (trace[i]) begin
            if (trace[i][8]) grants.push_back(0);
            if (trace[i][7]) grants.push_back(1);
            if (trace[i][6]) datas.push_back(trace[i][5:0]);
        end
        check("rr_grant_count", 32'(grants.size()), 32'd4);
        check("rr_data_count", 32'(datas.size()), 32'd4);
        if (grants.size() == 4) check("rr_order", {grants[0][1:0], grants[1][1:0], grants[2][1:0], grants[3][1:0]}, 8'b00_01_00_01);
        if (datas.size() == 4) check("rr_data", {datas[0], datas[1], datas[2], datas[3]}, {6'd10, 6'd20, 6'd11, 6'd21});
        tr_chk("rr_addr2", 3, {2'b00, 1'b0, 6'd2});

        // 5: reset during ADDR cycle
        do_reset();
        send(0, 6'd0, 6'd3);
        release_req(0);
        reset = 1'b1;
        #1;
        check("midrst_sel", bus_sel, 1'b0);
        check("midrst_val", bus_val, 6'h3F);
        check("midrst_busy", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        trace.delete();
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) tr_chk("midrst_idle", i, {2'b00, 1'b0, 6'h3F});
        check("max_phase_kept", core_regs[0], 6'd2);

        // 6: address change, no false hit
        trace.delete();
        send(0, 6'd5, 6'd1);
        send(0, 6'd0, 6'd4);
        release_req(0);
        repeat (4) @(posedge clk);
        #1;
        tr_chk("chg_accept", 0, {2'b10, 1'b0, 6'h3F});
        tr_chk("chg_addr5", 1, {2'b00, 1'b0, 6'd5});
        tr_chk("chg_d1", 2, {2'b10, 1'b1, 6'd1});
        tr_chk("chg_addr0", 3, {2'b00, 1'b0, 6'd0});
        tr_chk("chg_d4", 4, {2'b00, 1'b1, 6'd4});
        tr_chk("chg_shadow0", 5, {2'b00, 1'b0, 6'd0});
        check("core_r5", core_regs[5], 6'd1);
        check("core_r0", core_regs[0], 6'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
